// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, master adapter state
// encodings and small decode helpers.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] IDLE         = 3'd0;
  localparam logic [2:0] RD_ADDR      = 3'd1;
  localparam logic [2:0] RD_DATA      = 3'd2;
  localparam logic [2:0] WR_ADDR_DATA = 3'd3;
  localparam logic [2:0] WR_RESP      = 3'd4;
  localparam logic [2:0] DONE         = 3'd5;

  function automatic logic in_window(input logic [31:0] addr,
                                     input logic [31:0] start_addr,
                                     input logic [31:0] end_addr);
    return (addr >= start_addr) && (addr < end_addr);
  endfunction

  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
  endfunction

endpackage

// File: rtl/axi_lite_master_adapter_if.sv
// AXI4-Lite bus bundle between the master adapter and an AXI4-Lite slave.
interface axi_lite_master_adapter_if;

  logic [31:0] M_AXI_ARADDR;
  logic        M_AXI_ARVALID;
  logic        M_AXI_ARREADY;
  logic [2:0]  M_AXI_ARPROT;

  logic [31:0] M_AXI_RDATA;
  logic [1:0]  M_AXI_RRESP;
  logic        M_AXI_RVALID;
  logic        M_AXI_RREADY;

  logic [31:0] M_AXI_AWADDR;
  logic        M_AXI_AWVALID;
  logic        M_AXI_AWREADY;
  logic [2:0]  M_AXI_AWPROT;

  logic [31:0] M_AXI_WDATA;
  logic [3:0]  M_AXI_WSTRB;
  logic        M_AXI_WVALID;
  logic        M_AXI_WREADY;

  logic [1:0]  M_AXI_BRESP;
  logic        M_AXI_BVALID;
  logic        M_AXI_BREADY;

  modport master (
    output M_AXI_ARADDR, M_AXI_ARVALID, M_AXI_ARPROT, M_AXI_RREADY,
           M_AXI_AWADDR, M_AXI_AWVALID, M_AXI_AWPROT,
           M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID, M_AXI_BREADY,
    input  M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
           M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BRESP, M_AXI_BVALID
  );

  modport slave (
    input  M_AXI_ARADDR, M_AXI_ARVALID, M_AXI_ARPROT, M_AXI_RREADY,
           M_AXI_AWADDR, M_AXI_AWVALID, M_AXI_AWPROT,
           M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID, M_AXI_BREADY,
    output M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
           M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BRESP, M_AXI_BVALID
  );

endinterface

// File: rtl/axi_lite_master_adapter.sv
// Native valid/ready memory requests to AXI4-Lite master, one transaction at
// a time; requests outside the address window complete locally with an error.
module axi_lite_master_adapter
  import axi_lite_pkg::*;
#(
  parameter logic [31:0] START_ADDR = 32'h4000_0000,
  parameter logic [31:0] END_ADDR   = 32'h4000_4000,
  parameter logic [31:0] ERR_RDATA  = 32'h0000_0000
) (
  input  logic                             M_AXI_ACLK,
  input  logic                             reset_i,
  input  logic                             valid_i,
  output logic                             ready_o,
  input  logic [31:0]                      addr_i,
  input  logic [31:0]                      wdata_i,
  input  logic [3:0]                       wstrb_i,
  output logic [31:0]                      rdata_o,
  output logic                             err_o,
  axi_lite_master_adapter_if.master        m_axi
);

  logic [2:0]  state;
  logic [31:0] araddr;
  logic [31:0] awaddr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        arvalid;
  logic        rready;
  logic        awvalid;
  logic        wvalid;
  logic        bready;
  logic        aw_done;
  logic        w_done;
  logic        aw_fire;
  logic        w_fire;
  logic        both_done;

  assign m_axi.M_AXI_ARADDR  = araddr;
  assign m_axi.M_AXI_ARVALID = arvalid;
  assign m_axi.M_AXI_ARPROT  = '0;
  assign m_axi.M_AXI_RREADY  = rready;
  assign m_axi.M_AXI_AWADDR  = awaddr;
  assign m_axi.M_AXI_AWVALID = awvalid;
  assign m_axi.M_AXI_AWPROT  = '0;
  assign m_axi.M_AXI_WDATA   = wdata;
  assign m_axi.M_AXI_WSTRB   = wstrb;
  assign m_axi.M_AXI_WVALID  = wvalid;
  assign m_axi.M_AXI_BREADY  = bready;

  assign aw_fire   = awvalid & m_axi.M_AXI_AWREADY;
  assign w_fire    = wvalid & m_axi.M_AXI_WREADY;
  assign both_done = (aw_done | aw_fire) & (w_done | w_fire);

  always_ff @(posedge M_AXI_ACLK or negedge reset_i) begin
    if (!reset_i) begin
      state   <= IDLE;
      araddr  <= '0;
      awaddr  <= '0;
      wdata   <= '0;
      wstrb   <= '0;
      arvalid <= 1'b0;
      rready  <= 1'b0;
      awvalid <= 1'b0;
      wvalid  <= 1'b0;
      bready  <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      ready_o <= 1'b0;
      err_o   <= 1'b0;
      rdata_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          ready_o <= 1'b0;
          err_o   <= 1'b0;
          // The requester still holds valid_i on the edge it samples ready_o.
          if (valid_i && !ready_o) begin
            if (!in_window(addr_i, START_ADDR, END_ADDR)) begin
              err_o   <= 1'b1;
              rdata_o <= ERR_RDATA;
              state   <= DONE;
            end else if (wstrb_i == '0) begin
              araddr  <= addr_i;
              arvalid <= 1'b1;
              state   <= RD_ADDR;
            end else begin
              awaddr  <= addr_i;
              wdata   <= wdata_i;
              wstrb   <= wstrb_i;
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
              state   <= WR_ADDR_DATA;
            end
          end
        end
        RD_ADDR: begin
          if (m_axi.M_AXI_ARREADY) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (m_axi.M_AXI_RVALID) begin
            rready  <= 1'b0;
            rdata_o <= m_axi.M_AXI_RDATA;
            err_o   <= resp_is_err(m_axi.M_AXI_RRESP);
            state   <= DONE;
          end
        end
        WR_ADDR_DATA: begin
          if (aw_fire) awvalid <= 1'b0;
          if (w_fire)  wvalid  <= 1'b0;
          if (both_done) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            bready  <= 1'b1;
            state   <= WR_RESP;
          end else begin
            if (aw_fire) aw_done <= 1'b1;
            if (w_fire)  w_done  <= 1'b1;
          end
        end
        WR_RESP: begin
          if (m_axi.M_AXI_BVALID) begin
            bready  <= 1'b0;
            err_o   <= resp_is_err(m_axi.M_AXI_BRESP);
            rdata_o <= '0;
            state   <= DONE;
          end
        end
        DONE: begin
          ready_o <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_master_adapter.sv
// Directed table-driven bench for axi_lite_master_adapter with a
// configurable-latency AXI4-Lite slave and protocol monitor.
`timescale 1ns/1ps
module tb_axi_lite_master_adapter;
  import axi_lite_pkg::*;

  localparam logic [31:0] ERR_RD = 32'hDEAD_0E44;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        valid = 1'b0;
  logic        ready;
  logic        err;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic [3:0]  wstrb = '0;

  axi_lite_master_adapter_if bus();

  axi_lite_master_adapter #(
    .START_ADDR(32'h4000_0000),
    .END_ADDR  (32'h4000_4000),
    .ERR_RDATA (ERR_RD)
  ) dut (
    .M_AXI_ACLK(clk),
    .reset_i   (rst_n),
    .valid_i   (valid),
    .ready_o   (ready),
    .addr_i    (addr),
    .wdata_i   (wdata),
    .wstrb_i   (wstrb),
    .rdata_o   (rdata),
    .err_o     (err),
    .m_axi     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          ar_lat;
    int          aw_lat;
    int          w_lat;
    int          r_lat;
    int          b_lat;
    logic [31:0] sdata;
    logic [1:0]  sresp;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_ar;
    int          exp_aw;
  } vec_t;

  vec_t vecs[10];

  int tests = 0;
  int fails = 0;

  // slave configuration, written by the stimulus process only
  int          cfg_ar_lat = 0, cfg_aw_lat = 0, cfg_w_lat = 0, cfg_r_lat = 0, cfg_b_lat = 0;
  logic [31:0] cfg_sdata = '0;
  logic [1:0]  cfg_sresp = '0;

  // monitor results, written by the slave process only
  int          n_ar = 0, n_aw = 0, n_w = 0, n_rdy = 0, n_vcyc = 0, proto_err = 0;
  int          cyc = 0, aw_cyc = 0, w_cyc = 0;
  logic [31:0] hs_araddr = '0, hs_awaddr = '0, hs_wdata = '0;
  logic [3:0]  hs_wstrb = '0;

  // Slave model and protocol monitor, evaluated on the falling edge so
  // handshake flags describe the following rising edge.
  initial begin
    bit ar_hs, r_hs, aw_hs, w_hs, b_hs;
    bit r_pend, aw_got, w_got, b_pend;
    bit p_arv, p_awv, p_wv;
    logic [31:0] p_araddr, p_awaddr, p_wdata;
    logic [3:0]  p_wstrb;
    int ar_c, aw_c, w_c, r_c, b_c;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bus.M_AXI_ARREADY = 1'b0; bus.M_AXI_RVALID = 1'b0; bus.M_AXI_RDATA = '0;
        bus.M_AXI_RRESP = '0; bus.M_AXI_AWREADY = 1'b0; bus.M_AXI_WREADY = 1'b0;
        bus.M_AXI_BVALID = 1'b0; bus.M_AXI_BRESP = '0;
        ar_hs = 0; r_hs = 0; aw_hs = 0; w_hs = 0; b_hs = 0;
        r_pend = 0; aw_got = 0; w_got = 0; b_pend = 0;
        p_arv = 0; p_awv = 0; p_wv = 0;
        p_araddr = '0; p_awaddr = '0; p_wdata = '0; p_wstrb = '0;
        ar_c = 0; aw_c = 0; w_c = 0; r_c = 0; b_c = 0;
      end else begin
        cyc++;
        if (p_arv && !ar_hs && (!bus.M_AXI_ARVALID || bus.M_AXI_ARADDR !== p_araddr)) proto_err++;
        if (p_awv && !aw_hs && (!bus.M_AXI_AWVALID || bus.M_AXI_AWADDR !== p_awaddr)) proto_err++;
        if (p_wv && !w_hs && (!bus.M_AXI_WVALID || bus.M_AXI_WDATA !== p_wdata ||
                              bus.M_AXI_WSTRB !== p_wstrb)) proto_err++;
        if (bus.M_AXI_BREADY && (bus.M_AXI_AWVALID || bus.M_AXI_WVALID)) proto_err++;
        if (bus.M_AXI_RREADY && bus.M_AXI_ARVALID) proto_err++;

        if (ar_hs) begin r_pend = 1; r_c = 0; end
        if (r_hs) bus.M_AXI_RVALID = 1'b0;
        if (aw_hs) aw_got = 1;
        if (w_hs) w_got = 1;
        if (b_hs) bus.M_AXI_BVALID = 1'b0;

        if (bus.M_AXI_ARVALID) begin bus.M_AXI_ARREADY = (ar_c >= cfg_ar_lat); ar_c++; end
        else begin bus.M_AXI_ARREADY = 1'b0; ar_c = 0; end
        if (bus.M_AXI_AWVALID) begin bus.M_AXI_AWREADY = (aw_c >= cfg_aw_lat); aw_c++; end
        else begin bus.M_AXI_AWREADY = 1'b0; aw_c = 0; end
        if (bus.M_AXI_WVALID) begin bus.M_AXI_WREADY = (w_c >= cfg_w_lat); w_c++; end
        else begin bus.M_AXI_WREADY = 1'b0; w_c = 0; end

        if (r_pend && !bus.M_AXI_RVALID) begin
          if (r_c >= cfg_r_lat) begin
            bus.M_AXI_RVALID = 1'b1; bus.M_AXI_RDATA = cfg_sdata; bus.M_AXI_RRESP = cfg_sresp;
            r_pend = 0;
          end else r_c++;
        end
        if (aw_got && w_got) begin aw_got = 0; w_got = 0; b_pend = 1; b_c = 0; end
        if (b_pend && !bus.M_AXI_BVALID) begin
          if (b_c >= cfg_b_lat) begin
            bus.M_AXI_BVALID = 1'b1; bus.M_AXI_BRESP = cfg_sresp; b_pend = 0;
          end else b_c++;
        end

        ar_hs = bus.M_AXI_ARVALID && bus.M_AXI_ARREADY;
        aw_hs = bus.M_AXI_AWVALID && bus.M_AXI_AWREADY;
        w_hs  = bus.M_AXI_WVALID && bus.M_AXI_WREADY;
        r_hs  = bus.M_AXI_RVALID && bus.M_AXI_RREADY;
        b_hs  = bus.M_AXI_BVALID && bus.M_AXI_BREADY;
        if (ar_hs) begin n_ar++; hs_araddr = bus.M_AXI_ARADDR; end
        if (aw_hs) begin n_aw++; aw_cyc = cyc; hs_awaddr = bus.M_AXI_AWADDR; end
        if (w_hs) begin n_w++; w_cyc = cyc; hs_wdata = bus.M_AXI_WDATA; hs_wstrb = bus.M_AXI_WSTRB; end
        if (ready) n_rdy++;
        if (bus.M_AXI_ARVALID || bus.M_AXI_AWVALID || bus.M_AXI_WVALID) n_vcyc++;

        p_arv = bus.M_AXI_ARVALID; p_araddr = bus.M_AXI_ARADDR;
        p_awv = bus.M_AXI_AWVALID; p_awaddr = bus.M_AXI_AWADDR;
        p_wv  = bus.M_AXI_WVALID;  p_wdata  = bus.M_AXI_WDATA; p_wstrb = bus.M_AXI_WSTRB;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Call at posedge+#1; returns at posedge+#1 one edge after ready_o was seen.
  task automatic do_req(input vec_t v, input string tag);
    int lat;
    bit seen;
    int ar0, aw0, w0, rdy0, vc0;
    cfg_ar_lat = v.ar_lat; cfg_aw_lat = v.aw_lat; cfg_w_lat = v.w_lat;
    cfg_r_lat = v.r_lat; cfg_b_lat = v.b_lat; cfg_sdata = v.sdata; cfg_sresp = v.sresp;
    ar0 = n_ar; aw0 = n_aw; w0 = n_w; rdy0 = n_rdy; vc0 = n_vcyc;
    valid = 1'b1; addr = v.addr; wdata = v.wdata; wstrb = v.wstrb;
    @(posedge clk);
    lat = 0;
    seen = 0;
    while (!seen && lat < 60) begin
      @(posedge clk); #1;
      lat++;
      seen = (ready === 1'b1);
    end
    check({tag, "_done"}, seen, 1);
    check({tag, "_lat"}, lat, v.exp_lat);
    check({tag, "_rdata"}, rdata, v.exp_rdata);
    check({tag, "_err"}, err, v.exp_err);
    @(posedge clk); #1;
    valid = 1'b0; wstrb = '0;
    check({tag, "_pulse_low"}, ready, 0);
    check({tag, "_nready"}, n_rdy - rdy0, 1);
    check({tag, "_n_ar"}, n_ar - ar0, v.exp_ar);
    check({tag, "_n_aw"}, n_aw - aw0, v.exp_aw);
    check({tag, "_n_w"}, n_w - w0, v.exp_aw);
    if (v.exp_ar != 0) check({tag, "_araddr"}, hs_araddr, v.addr);
    if (v.exp_aw != 0) begin
      check({tag, "_awaddr"}, hs_awaddr, v.addr);
      check({tag, "_wdata"}, hs_wdata, v.wdata);
      check({tag, "_wstrb"}, hs_wstrb, v.wstrb);
    end
    if (v.exp_ar == 0 && v.exp_aw == 0) check({tag, "_novalid"}, n_vcyc - vc0, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ar0, aw0, rdy0;

    vecs[0] = '{32'h4000_0010, 32'h0, 4'h0, 0, 0, 0, 0, 0, 32'hCAFE_F00D, RESP_OKAY,   32'hCAFE_F00D, 1'b0, 3, 1, 0};
    vecs[1] = '{32'h4000_0020, 32'h1234_5678, 4'b0011, 0, 4, 0, 0, 0, 32'h0, RESP_OKAY, 32'h0, 1'b0, 7, 0, 1};
    vecs[2] = '{32'h4000_0040, 32'h0, 4'h0, 10, 0, 0, 0, 0, 32'hDEAD_BEEF, RESP_SLVERR, 32'hDEAD_BEEF, 1'b1, 13, 1, 0};
    vecs[3] = '{32'h4000_4000, 32'h0, 4'h0, 0, 0, 0, 0, 0, 32'h5555_5555, RESP_OKAY,   ERR_RD, 1'b1, 1, 0, 0};
    vecs[4] = '{32'h4000_3FFC, 32'h0, 4'h0, 0, 0, 0, 0, 0, 32'h1111_2222, RESP_OKAY,   32'h1111_2222, 1'b0, 3, 1, 0};
    vecs[5] = '{32'h3FFF_FFFC, 32'hA5A5_A5A5, 4'hF, 0, 0, 0, 0, 0, 32'h0, RESP_OKAY, ERR_RD, 1'b1, 1, 0, 0};
    vecs[6] = '{32'h4000_3FFF, 32'h0, 4'h0, 0, 0, 0, 0, 0, 32'h3333_4444, RESP_EXOKAY, 32'h3333_4444, 1'b0, 3, 1, 0};
    vecs[7] = '{32'h4000_0000, 32'h0BAD_F00D, 4'b1000, 0, 0, 0, 0, 2, 32'h0, RESP_DECERR, 32'h0, 1'b1, 5, 0, 1};
    vecs[8] = '{32'h4000_0004, 32'h7777_8888, 4'b0100, 0, 0, 3, 0, 0, 32'h0, RESP_OKAY, 32'h0, 1'b0, 6, 0, 1};
    vecs[9] = '{32'h4000_0101, 32'h0, 4'h0, 0, 0, 0, 2, 0, 32'h5A5A_A5A5, RESP_OKAY,   32'h5A5A_A5A5, 1'b0, 5, 1, 0};

    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ctrl", {bus.M_AXI_ARVALID, bus.M_AXI_AWVALID, bus.M_AXI_WVALID,
                         bus.M_AXI_RREADY, bus.M_AXI_BREADY, ready, err}, 0);
    check("reset_addr", {bus.M_AXI_ARADDR, bus.M_AXI_AWADDR}, 0);
    check("reset_data", {bus.M_AXI_WDATA, rdata}, 0);
    check("reset_wstrb", bus.M_AXI_WSTRB, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) do_req(vecs[i], $sformatf("vec%0d", i));

    do_req(vecs[1], "wfirst");
    check("wfirst_gap", aw_cyc - w_cyc, 4);

    ar0 = n_ar; aw0 = n_aw; rdy0 = n_rdy;
    do_req(vecs[0], "b2b_rd");
    do_req(vecs[1], "b2b_wr");
    check("b2b_n_ar", n_ar - ar0, 1);
    check("b2b_n_aw", n_aw - aw0, 1);
    check("b2b_nready", n_rdy - rdy0, 2);

    // reset while the write address channel is stalled
    cfg_aw_lat = 20; cfg_w_lat = 20;
    rdy0 = n_rdy;
    valid = 1'b1; addr = 32'h4000_0080; wdata = 32'h0F0F_0F0F; wstrb = 4'hF;
    @(posedge clk);
    @(posedge clk); #1;
    check("rst_pre_awvalid", bus.M_AXI_AWVALID, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_ctrl", {bus.M_AXI_ARVALID, bus.M_AXI_AWVALID, bus.M_AXI_WVALID,
                             bus.M_AXI_RREADY, bus.M_AXI_BREADY, ready, err}, 0);
    check("rst_async_awaddr", bus.M_AXI_AWADDR, 0);
    valid = 1'b0; wstrb = '0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("rst_no_ready", n_rdy - rdy0, 0);
    do_req(vecs[4], "post_rst");

    ar0 = n_ar; aw0 = n_aw; rdy0 = n_rdy;
    repeat (5) @(posedge clk);
    #1;
    check("idle_n_ar", n_ar - ar0, 0);
    check("idle_n_aw", n_aw - aw0, 0);
    check("idle_nready", n_rdy - rdy0, 0);
    check("protocol_errors", proto_err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/axi_lite_master_adapter.md
Name: axi_lite_master_adapter

Overview:
- Bridges the team's native memory interface (valid/ready, addr, wdata, wstrb, rdata) to an AXI4-Lite master port; the initiator-side counterpart of the existing AXI4-Lite slave adapter.
- Lets a CPU core or DMA-style requester drive any AXI4-Lite peripheral, including a slave adapter.
- Handles one outstanding transaction at a time; in-window requests become AXI transactions; out-of-window requests complete locally with an error.

Parameters:
START_ADDR, 32'h4000_0000, first mapped byte address (inclusive)
END_ADDR, 32'h4000_4000, end of mapped window (exclusive)
ERR_RDATA, 32'h0000_0000, rdata_o value returned on a local decode error

Ports:
M_AXI_ACLK  in  1  clock for both interfaces
reset_i  in  1  asynchronous active-low reset
valid_i  in  1  request valid; held high until ready_o is seen
ready_o  out  1  one-cycle completion pulse
addr_i  in  32  request byte address
wdata_i  in  32  write data
wstrb_i  in  4  byte strobes; nonzero = write, zero = read
rdata_o  out  32  read data, valid while ready_o=1
err_o  out  1  error flag, valid while ready_o=1
M_AXI_ARADDR/ARVALID/ARREADY  out/out/in  32/1/1  read address channel
M_AXI_ARPROT, M_AXI_AWPROT  out  3  tied 3'b000
M_AXI_RDATA/RRESP/RVALID/RREADY  in/in/in/out  32/2/1/1  read data channel
M_AXI_AWADDR/AWVALID/AWREADY  out/out/in  32/1/1  write address channel
M_AXI_WDATA/WSTRB/WVALID/WREADY  out/out/out/in  32/4/1/1  write data channel
M_AXI_BRESP/BVALID/BREADY  in/in/out  2/1/1  write response channel

Behaviour:
- Reset (reset_i=0, asynchronous): state=IDLE. All outputs are 0: every VALID, RREADY, BREADY, ready_o, err_o, rdata_o, ARADDR, AWADDR, WDATA and WSTRB.
- Reset mid-transaction aborts immediately. No completion is reported.
- All outputs are registered. No combinational path exists from any input to any output.
- State IDLE: on valid_i=1, latch addr/wdata/wstrb and decode the window (START_ADDR <= addr_i < END_ADDR, unsigned).
  - Out of window -> DONE with err_o=1 and rdata_o=ERR_RDATA; no AXI activity.
  - In window, wstrb_i==0 -> RD_ADDR with ARVALID=1 and ARADDR=addr_i.
  - In window, wstrb_i!=0 -> WR_ADDR_DATA with AWVALID=1, WVALID=1 and AWADDR/WDATA/WSTRB driven from the latched request.
- State RD_ADDR: hold ARVALID and ARADDR stable until ARREADY is sampled high. On that edge: ARVALID=0, RREADY=1, go to RD_DATA.
- State RD_DATA: on RVALID sampled high, do all of the following, then go to DONE:
  - RREADY=0.
  - rdata_o=RDATA.
  - err_o=RRESP[1] (SLVERR and DECERR are errors; OKAY and EXOKAY are not).
- State WR_ADDR_DATA: AW and W channels are independent, with one done flag each.
  - AWVALID drops on the edge where AWREADY is sampled high.
  - WVALID drops on the edge where WREADY is sampled high.
  - Both channels may complete on the same edge, in either order, or with any gap between them.
  - Once both flags are set: clear the flags, BREADY=1, go to WR_RESP.
- State WR_RESP: on BVALID sampled high: BREADY=0, err_o=BRESP[1], rdata_o=0, go to DONE.
- State DONE: ready_o=1 for exactly one cycle, then IDLE with ready_o=0, err_o=0, rdata_o held.
- The requester drops valid_i on the edge where it samples ready_o=1. IDLE therefore never re-accepts the completed request.
- VALID signals never depend combinationally on READY. Once asserted, a VALID stays asserted with a stable payload until its handshake.
- Best-case latency from the valid_i sample edge to ready_o high, with slave ready/valid already high:
  - read: 3 cycles.
  - write: 3 cycles.
  - decode error: 1 cycle.
- Boundaries: addr = END_ADDR-1 is in window; addr = END_ADDR is out of window; addr = START_ADDR-1 is out of window. Unaligned addresses pass through unchanged.

Decomposition:
- Shared package axi_lite_pkg:
  - response codes RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11.
  - state encodings IDLE, RD_ADDR, RD_DATA, WR_ADDR_DATA, WR_RESP, DONE (3 bits).
- No sub-module. The window decode is a single comparison inside the block.

Test Plan:
- Read, addr 32'h4000_0010, slave ARREADY=1, RVALID returned 1 cycle later with RDATA=32'hCAFE_F00D, RRESP=OKAY -> ARADDR=32'h4000_0010 for exactly 1 handshake; ready_o pulses once, 3 cycles after the request; rdata_o=32'hCAFE_F00D, err_o=0.
- Write, addr 32'h4000_0020, wdata 32'h1234_5678, wstrb 4'b0011:
  - slave raises WREADY 4 cycles before AWREADY -> WVALID drops first, AWVALID held until its handshake, BREADY rises only after both handshakes.
  - BRESP=OKAY -> ready_o once, err_o=0.
- Slave stalls ARREADY 10 cycles, then RRESP=SLVERR -> ARVALID and ARADDR stable for all 10 cycles; ready_o once with err_o=1.
- Addr 32'h4000_4000 read, and addr 32'h3FFF_FFFC write -> no VALID ever asserted; ready_o 1 cycle after the request with err_o=1 and rdata_o=ERR_RDATA. Addr 32'h4000_3FFC is accepted.
- reset_i pulled low while in WR_ADDR_DATA with AWVALID=1 -> all VALID/READY outputs go to 0 immediately, without waiting for a clock edge; no ready_o. A subsequent read completes normally.
- Back-to-back read then write, with valid_i re-asserted the cycle after ready_o -> two distinct AXI transactions, two ready_o pulses, no duplicate transaction.
